spi_target: RTL and testbench
=============================

# spi_target

SPI mode-0 responder (CPOL=0, CPHA=0) clocked entirely in the system `clk` domain. It is the far end of the core-side `spi_controller`. An external master drives `spi_sck`, `spi_cs` and `spi_mosi`. The block oversamples those lines, shifts received bytes into a small first-word-fall-through RX FIFO, and serves transmit bytes from a one-byte TX holding register. Its MMIO-side handshake mirrors the controller's (`spi_rd`, `spi_wr`, `spi_din`, `spi_dout`, status flags), so the memory controller can map it as a peripheral. It is also used as a loop-back target in bench tests of `spi_controller`.

## Interface
- `DEPTH`, 4: RX FIFO depth in bytes; power of two, ≥2.
- `IDLE_BYTE`, 8'hFF: byte shifted out when the TX register is empty.

Ports (name, direction, width, meaning):
- `clk` in 1: single system clock.
- `Rst` in 1: reset, asynchronous, active-low.
- `spi_sck` in 1: master serial clock; asynchronous to `clk`.
- `spi_cs` in 1: chip select, active-low; asynchronous.
- `spi_mosi` in 1: master-out data; asynchronous.
- `spi_miso` out 1: target-out data, registered.
- `spi_wr` in 1: write `spi_din` into the TX register.
- `spi_din` in 8: TX byte.
- `spi_rd` in 1: pop the RX FIFO head.
- `spi_dout` out 8: RX FIFO head; 8'h00 when the FIFO is empty.
- `spi_data_avail` out 1: RX FIFO is non-empty.
- `spi_buffer_empty` out 1: TX register is empty.
- `spi_buffer_full` out 1: RX FIFO holds `DEPTH` bytes.
- `rx_overrun` out 1: sticky flag; a received byte was dropped.
- `cs_active` out 1: synchronized select is asserted.

## Operation
- **Synchronization and edge detect.** `spi_sck`, `spi_cs` and `spi_mosi` each pass through a 2-flop synchronizer. Edges are detected on the synchronized `spi_sck` and `spi_cs`.
- **States.** The FSM has two states, IDLE and ACTIVE.
  - IDLE → ACTIVE on a synchronized `spi_cs` falling edge.
  - ACTIVE → IDLE on a synchronized `spi_cs` rising edge.
  - Reset enters IDLE.
- **Entering ACTIVE.**
  - Load the TX shift register with the TX register contents if it is full (then mark the TX register empty), otherwise with `IDLE_BYTE`.
  - Clear `bit_cnt` (3 bits) to 0.
  - Drive `spi_miso` with shift[7].
- **sck rise, ACTIVE.**
  - `rx_shift <= {rx_shift[6:0], mosi_sync}`; `bit_cnt` increments and wraps 7 → 0.
  - On the wrap (8th bit), push the assembled byte into the RX FIFO.
  - If the FIFO is full and not popped in the same cycle, drop the byte and set `rx_overrun`.
- **sck fall, ACTIVE.**
  - If `bit_cnt` == 0 (byte boundary), load the next TX byte using the same rule as entering ACTIVE.
  - Otherwise shift the TX shift register left by one.
  - `spi_miso <= shift[7]` after the update.
- **IDLE.** `spi_miso` = 1. sck edges are ignored.
- **cs deasserted mid-byte.** Discard the partial RX bits with no push. `bit_cnt` returns to 0. A TX byte already loaded into the shift register is consumed (not restored).
- **TX register.**
  - `spi_wr` while empty: store `spi_din`, mark full.
  - `spi_wr` while full: ignored, unless a load occurs in the same cycle. In that case the load takes the old byte and the new byte is stored (register stays full).
- **RX FIFO.**
  - `spi_rd` while empty: ignored.
  - Push and pop in the same cycle: both performed; count unchanged; no overrun even when full.
  - Pointers are log2(`DEPTH`) bits plus a wrap bit.
- **`rx_overrun`.** Cleared by reset or by any `spi_rd`. If a set and a clear coincide, set wins.

## Timing
- **Reset values.** `spi_miso` = 1, `spi_dout` = 8'h00, `spi_data_avail` = 0, `spi_buffer_empty` = 1, `spi_buffer_full` = 0, `rx_overrun` = 0, `cs_active` = 0. FSM is in IDLE.
- **Reset mid-transfer.** All state clears immediately. After release, the block waits in IDLE for a fresh cs falling edge, even if `spi_cs` is still low.
- **Input-to-action latency.** A pin edge takes 3 `clk` cycles to act: 2 for synchronization, then 1 registered action. `spi_miso` is valid ≤3 `clk` after the sck fall or cs fall.
- **Master constraints.**
  - sck high and low phases each ≥4 `clk` periods.
  - cs-fall to first sck rise ≥4 `clk` periods.
  - Last sck fall to cs rise ≥4 `clk` periods.
- **MMIO-side latency.**
  - `spi_data_avail` and `spi_dout` are valid the cycle after the push.
  - `spi_buffer_empty` deasserts the cycle after `spi_wr`.
  - `spi_rd` takes effect at the clock edge; the new head is visible the next cycle.

## Test plan
- **Single byte.** TX register = 8'hA5; master sends 8'h3C. Expect: MISO sequence 1,0,1,0,0,1,0,1; FIFO holds 8'h3C; `spi_data_avail` = 1; `spi_buffer_empty` = 1.
- **Idle fill.** Master sends 3 bytes (8'h01, 8'h02, 8'h03) in one cs frame with TX never written. Expect: MISO reads 8'hFF ×3; FIFO pops 01, 02, 03 in order.
- **Overrun.** With `DEPTH` = 4, master sends 5 bytes without pops. Expect: `spi_buffer_full` after the 4th byte; the 5th byte dropped; `rx_overrun` = 1; the first `spi_rd` returns byte 1 and clears `rx_overrun`.
- **Abort.** cs rises after 5 sck cycles. Expect: no push; next frame byte 8'h81 is received intact; `bit_cnt` restarted.
- **Simultaneous push/pop.** FIFO full; `spi_rd` asserted on the push cycle. Expect: count stays 4; `rx_overrun` stays 0.
- **Reset mid-transfer.** `Rst` asserted low mid-byte with TX full. Expect: all reset values; no FIFO entry; new frame after cs toggle works.

Source files
------------

// File: rtl/spi_target.sv
// SPI mode-0 responder running entirely in the clk domain: oversampled pins,
// RX FIFO (first-word-fall-through) and a one-byte TX holding register.
module spi_target #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [7:0]  IDLE_BYTE = 8'hFF
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       spi_sck,
  input  logic       spi_cs,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic       spi_wr,
  input  logic [7:0] spi_din,
  input  logic       spi_rd,
  output logic [7:0] spi_dout,
  output logic       spi_data_avail,
  output logic       spi_buffer_empty,
  output logic       spi_buffer_full,
  output logic       rx_overrun,
  output logic       cs_active
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e          state_q, state_d;
  logic            sck_s1_q, sck_s2_q, sck_s3_q;
  logic            cs_s1_q, cs_s2_q, cs_s3_q;
  logic            mosi_s1_q, mosi_s2_q;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            miso_q, miso_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_full_q, tx_full_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic            overrun_q, overrun_d;

  logic            sck_rise, sck_fall, cs_rise, cs_fall;
  logic            load, push, pop, drop;
  logic            fifo_empty, fifo_full;
  logic [7:0]      tx_next, tx_upd, push_byte;
  logic [AW-1:0]   wr_idx, rd_idx;

  assign sck_rise   = sck_s2_q & ~sck_s3_q;
  assign sck_fall   = ~sck_s2_q & sck_s3_q;
  assign cs_fall    = ~cs_s2_q & cs_s3_q;
  assign cs_rise    = cs_s2_q & ~cs_s3_q;

  assign wr_idx     = wr_ptr_q[AW-1:0];
  assign rd_idx     = rd_ptr_q[AW-1:0];
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
  assign tx_next    = tx_full_q ? tx_data_q : IDLE_BYTE;
  assign push_byte  = {rx_shift_q[6:0], mosi_s2_q};

  // cs synchronizer resets to "selected" so a cs already low at reset release
  // does not look like a falling edge; a fresh high-to-low is required.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      sck_s1_q  <= 1'b0;
      sck_s2_q  <= 1'b0;
      sck_s3_q  <= 1'b0;
      cs_s1_q   <= 1'b0;
      cs_s2_q   <= 1'b0;
      cs_s3_q   <= 1'b0;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      sck_s1_q  <= spi_sck;
      sck_s2_q  <= sck_s1_q;
      sck_s3_q  <= sck_s2_q;
      cs_s1_q   <= spi_cs;
      cs_s2_q   <= cs_s1_q;
      cs_s3_q   <= cs_s2_q;
      mosi_s1_q <= spi_mosi;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      miso_q     <= 1'b1;
      tx_data_q  <= '0;
      tx_full_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overrun_q  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      miso_q     <= miso_d;
      tx_data_q  <= tx_data_d;
      tx_full_q  <= tx_full_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overrun_q  <= overrun_d;
      mem_q      <= mem_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    miso_d     = miso_q;
    tx_upd     = tx_shift_q;
    load       = 1'b0;
    push       = 1'b0;

    case (state_q)
      IDLE: begin
        miso_d = 1'b1;
        if (cs_fall) begin
          state_d    = ACTIVE;
          load       = 1'b1;
          tx_shift_d = tx_next;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          miso_d     = tx_next[7];
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          // Partial RX bits are dropped; an already-loaded TX byte stays consumed.
          state_d    = IDLE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          miso_d     = 1'b1;
        end else begin
          if (sck_rise) begin
            rx_shift_d = push_byte;
            bit_cnt_d  = bit_cnt_q + 3'd1;
            push       = (bit_cnt_q == 3'd7);
          end
          if (sck_fall) begin
            if (bit_cnt_q == 3'd0) begin
              load   = 1'b1;
              tx_upd = tx_next;
            end else begin
              tx_upd = {tx_shift_q[6:0], 1'b0};
            end
            tx_shift_d = tx_upd;
            miso_d     = tx_upd[7];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // TX holding register: a write while full is taken only when a load drains it.
  always_comb begin
    tx_data_d = tx_data_q;
    tx_full_d = tx_full_q;
    if (load) tx_full_d = 1'b0;
    if (spi_wr && (!tx_full_q || load)) begin
      tx_data_d = spi_din;
      tx_full_d = 1'b1;
    end
  end

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    overrun_d = overrun_q;
    pop       = spi_rd & ~fifo_empty;
    drop      = push & fifo_full & ~pop;
    if (push && !drop) begin
      mem_d[wr_idx] = push_byte;
      wr_ptr_d      = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (pop) rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    if (spi_rd) overrun_d = 1'b0;
    if (drop)   overrun_d = 1'b1;
  end

  assign spi_miso         = miso_q;
  assign spi_dout         = fifo_empty ? 8'h00 : mem_q[rd_idx];
  assign spi_data_avail   = ~fifo_empty;
  assign spi_buffer_empty = ~tx_full_q;
  assign spi_buffer_full  = fifo_full;
  assign rx_overrun       = overrun_q;
  assign cs_active        = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: acts as an SPI mode-0 master and MMIO host.
module tb_spi_target;

  logic       clk = 1'b0;
  logic       Rst = 1'b0;
  logic       spi_sck = 1'b0;
  logic       spi_cs = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       spi_wr = 1'b0;
  logic [7:0] spi_din = 8'h00;
  logic       spi_rd = 1'b0;
  logic [7:0] spi_dout;
  logic       spi_data_avail;
  logic       spi_buffer_empty;
  logic       spi_buffer_full;
  logic       rx_overrun;
  logic       cs_active;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [7:0]  m;

  spi_target #(.DEPTH(4), .IDLE_BYTE(8'hFF)) dut (
    .clk              (clk),
    .Rst              (Rst),
    .spi_sck          (spi_sck),
    .spi_cs           (spi_cs),
    .spi_mosi         (spi_mosi),
    .spi_miso         (spi_miso),
    .spi_wr           (spi_wr),
    .spi_din          (spi_din),
    .spi_rd           (spi_rd),
    .spi_dout         (spi_dout),
    .spi_data_avail   (spi_data_avail),
    .spi_buffer_empty (spi_buffer_empty),
    .spi_buffer_full  (spi_buffer_full),
    .rx_overrun       (rx_overrun),
    .cs_active        (cs_active)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Master shifts n bits MSB first; MISO is sampled just before each sck rise.
  task automatic spi_bits(input logic [7:0] b, input int unsigned n, output logic [7:0] mi);
    mi = '0;
    for (int unsigned i = 0; i < n; i++) begin
      spi_mosi = b[7-i];
      tick(5);
      mi[7-i] = spi_miso;
      spi_sck = 1'b1;
      tick(5);
      spi_sck = 1'b0;
    end
    tick(5);
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    tick(5);
  endtask

  task automatic cs_high();
    spi_cs = 1'b1;
    tick(6);
  endtask

  task automatic wr_tx(input logic [7:0] d);
    spi_din = d;
    spi_wr  = 1'b1;
    tick(1);
    spi_wr  = 1'b0;
  endtask

  task automatic pop();
    spi_rd = 1'b1;
    tick(1);
    spi_rd = 1'b0;
  endtask

  initial begin
    tick(3);
    chk("rst_miso",   {31'd0, spi_miso}, 32'd1);
    chk("rst_dout",   {24'd0, spi_dout}, 32'h00);
    chk("rst_avail",  {31'd0, spi_data_avail}, 32'd0);
    chk("rst_bempty", {31'd0, spi_buffer_empty}, 32'd1);
    chk("rst_bfull",  {31'd0, spi_buffer_full}, 32'd0);
    chk("rst_ovr",    {31'd0, rx_overrun}, 32'd0);
    chk("rst_csact",  {31'd0, cs_active}, 32'd0);
    Rst = 1'b1;
    tick(4);

    // Single byte: TX A5, master sends 3C
    wr_tx(8'hA5);
    chk("sb_bempty_wr", {31'd0, spi_buffer_empty}, 32'd0);
    cs_low();
    chk("sb_csact", {31'd0, cs_active}, 32'd1);
    chk("sb_bempty_ld", {31'd0, spi_buffer_empty}, 32'd1);
    spi_bits(8'h3C, 8, m);
    chk("sb_miso", {24'd0, m}, 32'hA5);
    chk("sb_avail", {31'd0, spi_data_avail}, 32'd1);
    chk("sb_dout", {24'd0, spi_dout}, 32'h3C);
    cs_high();
    chk("sb_idle_miso", {31'd0, spi_miso}, 32'd1);
    chk("sb_csact_off", {31'd0, cs_active}, 32'd0);
    pop();
    chk("sb_avail_pop", {31'd0, spi_data_avail}, 32'd0);
    chk("sb_dout_pop", {24'd0, spi_dout}, 32'h00);
    pop();
    chk("empty_rd_avail", {31'd0, spi_data_avail}, 32'd0);

    // Idle fill: three bytes, TX never written
    cs_low();
    spi_bits(8'h01, 8, m); chk("if_miso0", {24'd0, m}, 32'hFF);
    spi_bits(8'h02, 8, m); chk("if_miso1", {24'd0, m}, 32'hFF);
    spi_bits(8'h03, 8, m); chk("if_miso2", {24'd0, m}, 32'hFF);
    cs_high();
    chk("if_pop0", {24'd0, spi_dout}, 32'h01); pop();
    chk("if_pop1", {24'd0, spi_dout}, 32'h02); pop();
    chk("if_pop2", {24'd0, spi_dout}, 32'h03); pop();
    chk("if_empty", {31'd0, spi_data_avail}, 32'd0);

    // Write while full is ignored; second byte falls back to idle byte
    wr_tx(8'h5A);
    wr_tx(8'hC3);
    cs_low();
    spi_bits(8'h44, 8, m); chk("wf_miso0", {24'd0, m}, 32'h5A);
    spi_bits(8'h55, 8, m); chk("wf_miso1", {24'd0, m}, 32'hFF);
    cs_high();
    chk("wf_rx0", {24'd0, spi_dout}, 32'h44); pop();
    chk("wf_rx1", {24'd0, spi_dout}, 32'h55); pop();

    // Overrun: five bytes into a depth-4 FIFO
    cs_low();
    spi_bits(8'h10, 8, m);
    spi_bits(8'h11, 8, m);
    spi_bits(8'h12, 8, m);
    chk("ov_notfull", {31'd0, spi_buffer_full}, 32'd0);
    spi_bits(8'h13, 8, m);
    chk("ov_full4", {31'd0, spi_buffer_full}, 32'd1);
    chk("ov_ovr0", {31'd0, rx_overrun}, 32'd0);
    spi_bits(8'h14, 8, m);
    chk("ov_ovr1", {31'd0, rx_overrun}, 32'd1);
    cs_high();
    chk("ov_head", {24'd0, spi_dout}, 32'h10);
    pop();
    chk("ov_clr", {31'd0, rx_overrun}, 32'd0);
    chk("ov_notfull2", {31'd0, spi_buffer_full}, 32'd0);
    chk("ov_pop1", {24'd0, spi_dout}, 32'h11); pop();
    chk("ov_pop2", {24'd0, spi_dout}, 32'h12); pop();
    chk("ov_pop3", {24'd0, spi_dout}, 32'h13); pop();
    chk("ov_dropped", {31'd0, spi_data_avail}, 32'd0);

    // Abort after five sck cycles, then a clean byte
    cs_low();
    spi_bits(8'hF0, 5, m);
    cs_high();
    chk("ab_nopush", {31'd0, spi_data_avail}, 32'd0);
    cs_low();
    spi_bits(8'h81, 8, m);
    cs_high();
    chk("ab_avail", {31'd0, spi_data_avail}, 32'd1);
    chk("ab_byte", {24'd0, spi_dout}, 32'h81);
    pop();

    // Simultaneous push/pop with the FIFO full
    cs_low();
    spi_bits(8'h20, 8, m);
    spi_bits(8'h21, 8, m);
    spi_bits(8'h22, 8, m);
    spi_bits(8'h23, 8, m);
    chk("pp_full", {31'd0, spi_buffer_full}, 32'd1);
    spi_bits(8'h24, 7, m);
    spi_mosi = 1'b0;
    tick(5);
    spi_sck = 1'b1;
    tick(2);
    spi_rd = 1'b1;
    tick(1);
    spi_rd = 1'b0;
    chk("pp_full_kept", {31'd0, spi_buffer_full}, 32'd1);
    chk("pp_ovr", {31'd0, rx_overrun}, 32'd0);
    chk("pp_head", {24'd0, spi_dout}, 32'h21);
    tick(4);
    spi_sck = 1'b0;
    tick(5);
    cs_high();
    pop(); chk("pp_pop22", {24'd0, spi_dout}, 32'h22);
    pop(); chk("pp_pop23", {24'd0, spi_dout}, 32'h23);
    pop(); chk("pp_pop24", {24'd0, spi_dout}, 32'h24);
    pop(); chk("pp_empty", {31'd0, spi_data_avail}, 32'd0);

    // Reset mid-transfer with TX full
    wr_tx(8'h77);
    cs_low();
    spi_bits(8'hAA, 4, m);
    Rst = 1'b0;
    tick(1);
    chk("rm_miso", {31'd0, spi_miso}, 32'd1);
    chk("rm_avail", {31'd0, spi_data_avail}, 32'd0);
    chk("rm_bempty", {31'd0, spi_buffer_empty}, 32'd1);
    chk("rm_csact", {31'd0, cs_active}, 32'd0);
    Rst = 1'b1;
    tick(6);
    chk("rm_wait_idle", {31'd0, cs_active}, 32'd0);
    spi_bits(8'h99, 8, m);
    chk("rm_ign_miso", {24'd0, m}, 32'hFF);
    chk("rm_ign_avail", {31'd0, spi_data_avail}, 32'd0);
    cs_high();
    cs_low();
    spi_bits(8'h66, 8, m);
    cs_high();
    chk("rm_new_miso", {24'd0, m}, 32'hFF);
    chk("rm_new_byte", {24'd0, spi_dout}, 32'h66);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
